// File: rtl/pcileech_rmii_rx.sv
// pcileech_rmii_rx: RMII receive front-end for the NeTV2 Ethernet path.
// Strips preamble/SFD, assembles bytes LSB-dibit first, checks FCS and
// length, and streams bytes with first/last/error markers.
// Optional build macro: PCILEECH_RMII_RX_FCS_STRIP_EN removes the 4 FCS
// bytes from the output stream (rx_last then marks the last payload byte).

module pcileech_rmii_rx #(
  parameter int PARAM_MIN_FRAME_BYTES     = 64,
  parameter int PARAM_MAX_FRAME_BYTES     = 1518,
  parameter int PARAM_MIN_PREAMBLE_DIBITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eth_crs_dv,
  input  logic [1:0]  eth_rx_data,
  input  logic        eth_rx_err,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_first,
  output logic        rx_last,
  output logic        rx_err,
  output logic [15:0] stat_frames_ok,
  output logic [15:0] stat_frames_err
);

`ifdef PCILEECH_RMII_RX_FCS_STRIP_EN
  // Four FCS bytes plus the held-back payload byte stay inside the block so
  // the final payload byte is still available when EOF is seen.
  localparam int HOLD_DEPTH = 5;
`else
  localparam int HOLD_DEPTH = 1;
`endif

  localparam logic [10:0] MIN_BYTES = 11'(PARAM_MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_BYTES = 11'(PARAM_MAX_FRAME_BYTES);
  localparam logic [4:0]  MIN_PRE   = 5'(PARAM_MIN_PREAMBLE_DIBITS);
  localparam logic [2:0]  HOLD_N    = 3'(HOLD_DEPTH);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DROP} state_t;

  state_t      state, state_nxt;
  logic        crs_d1, crs_d2;
  logic [1:0]  data_d1, data_d2;
  logic        err_d1, err_d2;
  logic        accept, eof;
  logic        wait_idle;
  logic [4:0]  pre_cnt;
  logic [1:0]  dibit_cnt;
  logic [7:0]  byte_sr;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic        phy_err;
  logic        first_pending;
  logic [7:0]  held [HOLD_DEPTH];
  logic [2:0]  held_cnt;
  logic        held_full;
  logic [7:0]  new_byte;
  logic        byte_done;
  logic        frame_bad;
  logic        emit, emit_last, emit_err, silent_err;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // A low CRS_DV sample is still data if carrier returns on the next sample;
  // two consecutive lows mark the end of the frame.
  assign accept    = crs_d2 | crs_d1;
  assign eof       = ~crs_d2 & ~crs_d1;
  assign held_full = (held_cnt == HOLD_N);
  assign new_byte  = {data_d2, byte_sr[7:2]};
  assign frame_bad = (crc != CRC_RESIDUE) || (byte_cnt < MIN_BYTES) || dibit_cnt[1] || phy_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-cycle emit decisions.
  always_comb begin
    state_nxt  = state;
    byte_done  = 1'b0;
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_err   = 1'b0;
    silent_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !wait_idle && data_d2 == 2'b01) state_nxt = ST_PRE;
      end
      ST_PRE: begin
        if (eof) state_nxt = ST_IDLE;
        else if (accept && data_d2 != 2'b01) begin
          if (data_d2 == 2'b11 && pre_cnt >= MIN_PRE) state_nxt = ST_DATA;
          else                                        state_nxt = ST_DROP;
        end
      end
      ST_DATA: begin
        if (eof) begin
          state_nxt = ST_IDLE;
          if (held_full) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_err  = frame_bad;
          end else if (byte_cnt != 11'd0) begin
            silent_err = 1'b1;
          end
        end else if (accept && dibit_cnt == 2'd3) begin
          byte_done = 1'b1;
          if (byte_cnt == MAX_BYTES) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_err  = 1'b1;
            state_nxt = ST_DROP;
          end else if (held_full) begin
            emit = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (eof) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Input pipeline, byte assembly, CRC, hold-back buffer, outputs and stats.
  // The carrier stages reset high so a frame in progress at reset release
  // must end before a new one is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crs_d1          <= 1'b1;
      crs_d2          <= 1'b1;
      data_d1         <= 2'b00;
      data_d2         <= 2'b00;
      err_d1          <= 1'b0;
      err_d2          <= 1'b0;
      wait_idle       <= 1'b1;
      pre_cnt         <= 5'd0;
      dibit_cnt       <= 2'd0;
      byte_sr         <= 8'd0;
      byte_cnt        <= 11'd0;
      crc             <= 32'hFFFFFFFF;
      phy_err         <= 1'b0;
      first_pending   <= 1'b0;
      held_cnt        <= 3'd0;
      for (int i = 0; i < HOLD_DEPTH; i++) held[i] <= 8'd0;
      rx_valid        <= 1'b0;
      rx_data         <= 8'd0;
      rx_first        <= 1'b0;
      rx_last         <= 1'b0;
      rx_err          <= 1'b0;
      stat_frames_ok  <= 16'd0;
      stat_frames_err <= 16'd0;
    end else begin
      crs_d1  <= eth_crs_dv;
      crs_d2  <= crs_d1;
      data_d1 <= eth_rx_data;
      data_d2 <= data_d1;
      err_d1  <= eth_rx_err;
      err_d2  <= err_d1;
      if (eof) wait_idle <= 1'b0;

      rx_valid <= emit;
      rx_first <= emit & first_pending;
      rx_last  <= emit_last;
      rx_err   <= emit_err;
      if (emit) begin
        rx_data       <= held[HOLD_DEPTH-1];
        first_pending <= 1'b0;
      end
      if (emit_last) begin
        if (emit_err) stat_frames_err <= stat_frames_err + 16'd1;
        else          stat_frames_ok  <= stat_frames_ok + 16'd1;
      end else if (silent_err) begin
        stat_frames_err <= stat_frames_err + 16'd1;
      end

      if (state == ST_IDLE) begin
        pre_cnt <= 5'd1;
        phy_err <= accept & err_d2;
      end else if (state == ST_PRE || state == ST_DATA) begin
        if (accept && err_d2) phy_err <= 1'b1;
      end

      if (state == ST_PRE && accept && data_d2 == 2'b01 && pre_cnt != 5'd31)
        pre_cnt <= pre_cnt + 5'd1;

      if (state == ST_PRE && state_nxt == ST_DATA) begin
        crc           <= 32'hFFFFFFFF;
        dibit_cnt     <= 2'd0;
        byte_cnt      <= 11'd0;
        held_cnt      <= 3'd0;
        first_pending <= 1'b1;
      end

      if (state == ST_DATA && accept && !eof) begin
        byte_sr   <= new_byte;
        dibit_cnt <= dibit_cnt + 2'd1;
        if (byte_done && state_nxt == ST_DATA) begin
          crc <= crc32_byte(crc, new_byte);
          if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
          if (!held_full) held_cnt <= held_cnt + 3'd1;
          for (int i = HOLD_DEPTH-1; i > 0; i--) held[i] <= held[i-1];
          held[0] <= new_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcileech_rmii_rx.sv
// Testbench for pcileech_rmii_rx: directed and randomized frames checked
// against a frame-level reference model (byte list, FCS, length rules).

module tb_pcileech_rmii_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
    logic       e;
  } rx_beat_t;

  logic        clk;
  logic        rst;
  logic        eth_crs_dv;
  logic [1:0]  eth_rx_data;
  logic        eth_rx_err;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_first;
  logic        rx_last;
  logic        rx_err;
  logic [15:0] stat_frames_ok;
  logic [15:0] stat_frames_err;

  int          tests_run;
  int          tests_failed;
  logic [7:0]  frame_q[$];
  rx_beat_t    cap_q[$];
  rx_beat_t    exp_q[$];
  int          pre_dibits;
  bit          toggle_tail;
  int          err_at;
  int          rst_at;
  logic [15:0] mod_ok;
  logic [15:0] mod_err;

  pcileech_rmii_rx dut (
    .clk             (clk),
    .rst             (rst),
    .eth_crs_dv      (eth_crs_dv),
    .eth_rx_data     (eth_rx_data),
    .eth_rx_err      (eth_rx_err),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_first        (rx_first),
    .rx_last         (rx_last),
    .rx_err          (rx_err),
    .stat_frames_ok  (stat_frames_ok),
    .stat_frames_err (stat_frames_err)
  );

  // 50 MHz reference clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Collect every emitted byte, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) cap_q.push_back(rx_beat_t'({rx_data, rx_first, rx_last, rx_err}));
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard Ethernet FCS over the first n bytes of frame_q.
  function automatic logic [31:0] refCrc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frame_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic appendFcs();
    logic [31:0] fcs;
    fcs = refCrc(frame_q.size());
    frame_q.push_back(fcs[7:0]);
    frame_q.push_back(fcs[15:8]);
    frame_q.push_back(fcs[23:16]);
    frame_q.push_back(fcs[31:24]);
  endtask

  task automatic buildCounting(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'(i));
    appendFcs();
  endtask

  task automatic buildRandom(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
    appendFcs();
  endtask

  // Frame-level expectation: bytes pass through (truncated at 1518), with
  // error if runt, giant, bad FCS or a PHY error inside the frame.
  task automatic modelFrame();
    int          n;
    int          m;
    logic        bad;
    logic [31:0] fcs_rx;
    n = frame_q.size();
    if (pre_dibits < 8 || n == 0) return;
    bad = (n < 64) || (n > 1518) || (err_at >= 0 && err_at < n);
    if (n < 4) bad = 1'b1;
    else begin
      fcs_rx = {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
      if (refCrc(n-4) != fcs_rx) bad = 1'b1;
    end
    m = (n > 1518) ? 1518 : n;
    for (int i = 0; i < m; i++)
      exp_q.push_back(rx_beat_t'({frame_q[i], (i == 0), (i == m-1), ((i == m-1) && bad)}));
    if (bad) mod_err = mod_err + 16'd1;
    else     mod_ok  = mod_ok + 16'd1;
  endtask

  task automatic sendDibit(input logic crs, input logic [1:0] d, input logic err);
    @(negedge clk);
    eth_crs_dv  = crs;
    eth_rx_data = d;
    eth_rx_err  = err;
  endtask

  // Drive preamble, SFD, frame_q bytes LSB-dibit first, then an idle gap.
  task automatic applyStimulus(input int gap);
    int   n;
    logic crs;
    n = frame_q.size();
    for (int i = 0; i < pre_dibits; i++) sendDibit(1'b1, 2'b01, 1'b0);
    sendDibit(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        crs = 1'b1;
        if (toggle_tail && (i*4 + k) >= (n*4 - 8) && (k % 2) == 0) crs = 1'b0;
        sendDibit(crs, frame_q[i][2*k +: 2], (err_at == i && k == 0));
        if (rst_at == i && k == 0) rst = 1'b1;
        if (rst_at == i && k == 2) rst = 1'b0;
      end
    end
    for (int i = 0; i < gap; i++) sendDibit(1'b0, 2'b00, 1'b0);
    if (rst_at < 0) modelFrame();
  endtask

  task automatic checkOutput(input string tag);
    int bad_i;
    repeat (16) @(negedge clk);
    checkValue({tag, "_count"}, cap_q.size(), exp_q.size());
    bad_i = -1;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      if (cap_q[i] !== exp_q[i]) begin
        bad_i = i;
        break;
      end
    end
    checkValue({tag, "_first_bad_beat"}, bad_i, -1);
    checkValue({tag, "_stat_ok"}, stat_frames_ok, mod_ok);
    checkValue({tag, "_stat_err"}, stat_frames_err, mod_err);
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lasts;
    tests_run    = 0;
    tests_failed = 0;
    mod_ok       = 16'd0;
    mod_err      = 16'd0;
    pre_dibits   = 31;
    toggle_tail  = 1'b0;
    err_at       = -1;
    rst_at       = -1;
    rst          = 1'b1;
    eth_crs_dv   = 1'b0;
    eth_rx_data  = 2'b00;
    eth_rx_err   = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkValue("reset_rx_valid", rx_valid, 0);
    checkValue("reset_rx_data", rx_data, 0);
    checkValue("reset_rx_first", rx_first, 0);
    checkValue("reset_rx_last", rx_last, 0);
    checkValue("reset_rx_err", rx_err, 0);
    checkValue("reset_stat_ok", stat_frames_ok, 0);
    checkValue("reset_stat_err", stat_frames_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Minimum-size good frame: 60 counting bytes plus FCS.
    buildCounting(60);
    applyStimulus(6);
    checkOutput("good64");

    // Same frame with one payload bit flipped.
    buildCounting(60);
    frame_q[10] = frame_q[10] ^ 8'h04;
    applyStimulus(6);
    checkOutput("bitflip");

    // Good frame with CRS_DV toggling over the final 8 dibits.
    buildCounting(60);
    toggle_tail = 1'b1;
    applyStimulus(6);
    toggle_tail = 1'b0;
    checkOutput("toggle_tail");

    // Short preamble is dropped; the next good frame is received.
    pre_dibits = 3;
    buildCounting(60);
    applyStimulus(4);
    pre_dibits = 31;
    buildRandom(80);
    applyStimulus(6);
    checkOutput("short_pre");

    // Giant frame truncated at the maximum length.
    buildRandom(1596);
    applyStimulus(6);
    checkOutput("giant");

    // Runt with a correct FCS.
    buildRandom(36);
    applyStimulus(6);
    checkOutput("runt");

    // PHY error pulsed once inside a good frame.
    buildCounting(60);
    err_at = 20;
    applyStimulus(6);
    err_at = -1;
    checkOutput("phy_err");

    // Reset mid-frame: no rx_last, counters cleared, next frame is clean.
    buildRandom(60);
    rst_at = 30;
    applyStimulus(6);
    rst_at = -1;
    repeat (16) @(negedge clk);
    lasts = 0;
    foreach (cap_q[i]) if (cap_q[i].l) lasts++;
    checkValue("rst_no_last", lasts, 0);
    mod_ok  = 16'd0;
    mod_err = 16'd0;
    checkValue("rst_stat_ok", stat_frames_ok, mod_ok);
    checkValue("rst_stat_err", stat_frames_err, mod_err);
    cap_q.delete();
    exp_q.delete();
    buildRandom(70);
    applyStimulus(6);
    checkOutput("after_rst");

    // Randomized frames, paired back-to-back with a minimal idle gap.
    for (int r = 0; r < 8; r++) begin
      buildRandom(int'($urandom_range(20, 160)));
      if ($urandom_range(0, 3) == 0)
        frame_q[$urandom_range(0, frame_q.size() - 1)] ^= (8'h01 << $urandom_range(0, 7));
      pre_dibits  = int'($urandom_range(8, 31));
      toggle_tail = 1'($urandom_range(0, 1));
      applyStimulus((r % 2 == 0) ? 2 : int'($urandom_range(3, 10)));
      toggle_tail = 1'b0;
      if (r % 2 == 1) checkOutput($sformatf("random%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
